// File: rtl/aes_pkg.sv
// Shared AES-256 definitions: round count, key-schedule width, FSM encodings,
// round-key selection, inverse S-box and the inverse linear-layer transforms.
package aes_pkg;

  localparam int NR         = 14;
  localparam int KEYW       = 128 * (NR + 1);
  localparam int LOOP_STEPS = 4 * (NR - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    LOOP = 2'd2,
    POST = 2'd3
  } state_e;

  // Byte b of the table sits at bits [2047-8*b -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [127:0] rk_sel(input logic [KEYW-1:0] key, input logic [3:0] idx);
    return key[KEYW-1-128*int'(idx) -: 128];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047-8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (0x09/0x0b/0x0d/0x0e) as an XOR of doublings.
  function automatic logic [7:0] gmul4(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  // Byte k of the block is bits [127-8k -: 8]; byte 4c+r is row r of column c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*(((c-r)+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul4(a0, 4'he) ^ gmul4(a1, 4'hb) ^ gmul4(a2, 4'hd) ^ gmul4(a3, 4'h9);
      o[119-32*c -: 8] = gmul4(a0, 4'h9) ^ gmul4(a1, 4'he) ^ gmul4(a2, 4'hb) ^ gmul4(a3, 4'hd);
      o[111-32*c -: 8] = gmul4(a0, 4'hd) ^ gmul4(a1, 4'h9) ^ gmul4(a2, 4'he) ^ gmul4(a3, 4'hb);
      o[103-32*c -: 8] = gmul4(a0, 4'hb) ^ gmul4(a1, 4'hd) ^ gmul4(a2, 4'h9) ^ gmul4(a3, 4'he);
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_sub_bytes.sv
// Sixteen parallel inverse S-box lookups over a 128-bit block; purely combinational.
module inv_sub_bytes
  import aes_pkg::*;
(
  input  logic [127:0] blk,
  output logic [127:0] res
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign res[8*i +: 8] = inv_sbox(blk[8*i +: 8]);
  end

endmodule

// File: rtl/inv_cipher.sv
// Iterative AES-256 inverse cipher: one transform per clock on a single state
// register, round keys picked from the caller-held expanded key schedule.
module inv_cipher
  import aes_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            basla,
  input  logic [127:0]    metin_i,
  input  logic [KEYW-1:0] key_i,
  output logic [127:0]    metin_o,
  output logic            bitti_o,
  output logic            mesgul_o
);

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   rkidx_q, rkidx_d;
  logic [5:0]   step_q, step_d;
  logic [127:0] out_d;
  logic         bitti_d;
  logic [127:0] rk_cur, sb_res;

  assign rk_cur = rk_sel(key_i, rkidx_q);

  inv_sub_bytes u_isb (
    .blk (st_q),
    .res (sb_res)
  );

  // Busy covers the whole run including the cycle the result is presented.
  assign mesgul_o = (state_q != IDLE) | bitti_o;

  // Next-state and datapath select: exactly one transform applied per cycle.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rkidx_d = rkidx_q;
    step_d  = step_q;
    out_d   = metin_o;
    bitti_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (basla) begin
          st_d    = metin_i;
          rkidx_d = 4'(NR);
          step_d  = '0;
          state_d = PRE;
        end
      end
      PRE: begin
        st_d    = st_q ^ rk_cur;
        rkidx_d = rkidx_q - 4'd1;
        step_d  = '0;
        state_d = LOOP;
      end
      LOOP: begin
        unique case (step_q[1:0])
          2'd0: st_d = inv_shift_rows(st_q);
          2'd1: st_d = sb_res;
          2'd2: begin
            st_d    = st_q ^ rk_cur;
            rkidx_d = rkidx_q - 4'd1;
          end
          default: st_d = inv_mix_columns(st_q);
        endcase
        if (step_q == 6'(LOOP_STEPS - 1)) begin
          step_d  = '0;
          state_d = POST;
        end else begin
          step_d = step_q + 6'd1;
        end
      end
      default: begin
        unique case (step_q[1:0])
          2'd0: begin
            st_d   = inv_shift_rows(st_q);
            step_d = step_q + 6'd1;
          end
          2'd1: begin
            st_d   = sb_res;
            step_d = step_q + 6'd1;
          end
          default: begin
            out_d   = st_q ^ rk_cur;
            bitti_d = 1'b1;
            step_d  = '0;
            state_d = IDLE;
          end
        endcase
      end
    endcase
  end

  // State, counters and result registers; reset aborts any block in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      st_q    <= '0;
      rkidx_q <= '0;
      step_q  <= '0;
      metin_o <= '0;
      bitti_o <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rkidx_q <= rkidx_d;
      step_q  <= step_d;
      metin_o <= out_d;
      bitti_o <= bitti_d;
    end
  end

endmodule

// File: tb/tb_inv_cipher.sv
// Bench for inv_cipher: forward AES-256 reference model plus a queue of expected plaintexts.
module tb_inv_cipher;

  logic          clk_i;
  logic          rst_ni;
  logic          basla;
  logic [127:0]  metin_i;
  logic [1919:0] key_i;
  logic [127:0]  metin_o;
  logic          bitti_o;
  logic          mesgul_o;

  int errors = 0;
  int checks = 0;

  logic [127:0] sb[$];
  logic [7:0]   sbox_t[256];

  inv_cipher dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .basla    (basla),
    .metin_i  (metin_i),
    .key_i    (key_i),
    .metin_o  (metin_o),
    .bitti_o  (bitti_o),
    .mesgul_o (mesgul_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- forward AES-256 reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] k);
    logic [31:0]   w[60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] o;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int i = 0; i < 60; i++) o[1919-32*i -: 32] = w[i];
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] ks);
    logic [127:0] s, o;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ ks[1919 -: 128];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sbox_t[s[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      s = o;
      if (rnd != 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        s = o;
      end
      s = s ^ ks[1919-128*rnd -: 128];
    end
    return s;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- drive helpers (no checking) ----------------
  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic start_block(input logic [127:0] ct, input logic [1919:0] ks,
                             input logic [127:0] pt, input bit keep);
    basla   = 1'b1;
    metin_i = ct;
    key_i   = ks;
    sb.push_back(pt);
    @(posedge clk_i);
    @(negedge clk_i);
    if (!keep) basla = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (bitti_o) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0; basla = 1'b0; metin_i = '0; key_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (bitti_o !== 1'b0) begin errors++; $display("FAIL reset_bitti: got %b want 0", bitti_o); end
    checks++; if (mesgul_o !== 1'b0) begin errors++; $display("FAIL reset_mesgul: got %b want 0", mesgul_o); end
    checks++; if (metin_o !== 128'h0) begin errors++; $display("FAIL reset_metin: got %h want 0", metin_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if (bitti_o !== 1'b0 || mesgul_o !== 1'b0 || metin_o !== 128'h0) begin
        errors++;
        $display("FAIL idle_quiet: cycle %0d got bitti=%b mesgul=%b metin=%h want 0/0/0",
                 i, bitti_o, mesgul_o, metin_o);
      end
    end
  endtask

  task automatic test_fips();
    logic [1919:0] ks;
    logic [127:0]  exp;
    int            n;
    ks = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    start_block(128'h8ea2b7ca516745bfeafc49904b496089, ks, 128'h00112233445566778899aabbccddeeff, 1'b0);
    checks++; if (mesgul_o !== 1'b1) begin errors++; $display("FAIL fips_busy_start: got %b want 1", mesgul_o); end
    wait_done(n);
    exp = sb.pop_front();
    checks++; if (n != 56) begin errors++; $display("FAIL fips_latency: got %0d want 56", n); end
    checks++; if (metin_o !== exp) begin errors++; $display("FAIL fips_result: got %h want %h", metin_o, exp); end
    checks++; if (mesgul_o !== 1'b1) begin errors++; $display("FAIL fips_busy_done: got %b want 1", mesgul_o); end
    @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (bitti_o !== 1'b0) begin errors++; $display("FAIL fips_pulse_width: got %b want 0", bitti_o); end
    checks++; if (mesgul_o !== 1'b0) begin errors++; $display("FAIL fips_busy_after: got %b want 0", mesgul_o); end
    checks++; if (metin_o !== exp) begin errors++; $display("FAIL fips_hold: got %h want %h", metin_o, exp); end
  endtask

  task automatic test_roundtrip();
    logic [1919:0] ks;
    logic [127:0]  pt, exp;
    int            n;
    for (int t = 0; t < 40; t++) begin
      ks = expand(rand256());
      pt = rand128();
      start_block(encrypt(pt, ks), ks, pt, 1'b0);
      wait_done(n);
      exp = sb.pop_front();
      checks++; if (n != 56) begin errors++; $display("FAIL rt_latency[%0d]: got %0d want 56", t, n); end
      checks++; if (metin_o !== exp) begin errors++; $display("FAIL rt_result[%0d]: got %h want %h", t, metin_o, exp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1919:0] ks;
    logic [127:0]  pt, exp;
    int            n, pulses;
    ks = expand(rand256());
    pt = rand128();
    start_block(encrypt(pt, ks), ks, pt, 1'b0);
    repeat (21) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    sb.delete();
    checks++; if (metin_o !== 128'h0) begin errors++; $display("FAIL abort_metin: got %h want 0", metin_o); end
    checks++; if (bitti_o !== 1'b0) begin errors++; $display("FAIL abort_bitti: got %b want 0", bitti_o); end
    checks++; if (mesgul_o !== 1'b0) begin errors++; $display("FAIL abort_mesgul: got %b want 0", mesgul_o); end
    rst_ni = 1'b1;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (bitti_o || mesgul_o) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", pulses); end
    pt = rand128();
    start_block(encrypt(pt, ks), ks, pt, 1'b0);
    wait_done(n);
    exp = sb.pop_front();
    checks++; if (n != 56) begin errors++; $display("FAIL after_reset_latency: got %0d want 56", n); end
    checks++; if (metin_o !== exp) begin errors++; $display("FAIL after_reset_result: got %h want %h", metin_o, exp); end
  endtask

  task automatic test_basla_held();
    logic [1919:0] ks;
    logic [127:0]  pt, exp;
    int            n, extra;
    ks = expand(rand256());
    pt = rand128();
    start_block(encrypt(pt, ks), ks, pt, 1'b1);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (bitti_o) begin
        n = i;
        break;
      end
      basla   = (i < 20) ? 1'b1 : ($urandom_range(0, 2) != 0);
      metin_i = rand128();
    end
    basla = 1'b0;
    exp = sb.pop_front();
    checks++; if (n != 56) begin errors++; $display("FAIL held_latency: got %0d want 56", n); end
    checks++; if (metin_o !== exp) begin errors++; $display("FAIL held_result: got %h want %h", metin_o, exp); end
    extra = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (bitti_o || mesgul_o) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL held_single: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [1919:0] ka, kb;
    logic [127:0]  pa, pb, expa, expb;
    int            n, gap, hold_bad;
    ka = expand(rand256());
    kb = expand(rand256());
    pa = rand128();
    pb = rand128();
    start_block(encrypt(pa, ka), ka, pa, 1'b0);
    wait_done(n);
    expa = sb.pop_front();
    checks++; if (metin_o !== expa) begin errors++; $display("FAIL b2b_first: got %h want %h", metin_o, expa); end
    start_block(encrypt(pb, kb), kb, pb, 1'b0);
    gap = -1;
    hold_bad = 0;
    for (int i = 2; i <= 200; i++) begin
      if (bitti_o) begin
        gap = i - 1;
        break;
      end
      if (metin_o !== expa) hold_bad++;
      @(posedge clk_i);
      @(negedge clk_i);
      if (bitti_o) begin
        gap = i;
        break;
      end
    end
    expb = sb.pop_front();
    checks++; if (gap != 57) begin errors++; $display("FAIL b2b_spacing: got %0d want 57", gap); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL b2b_hold: got %0d bad cycles want 0", hold_bad); end
    checks++; if (metin_o !== expb) begin errors++; $display("FAIL b2b_second: got %h want %h", metin_o, expb); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_idle();
    test_fips();
    test_roundtrip();
    test_reset_mid();
    test_basla_held();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
